// File: rtl/alu_wb_stage.sv
// Writeback stage behind the 16-bit ALU: buffers results, commits z/v/n flags in retire order,
// evaluates branch conditions and counts retirements. Define ALU_WB_SKID_EN for a 2-entry skid buffer.
module alu_wb_stage #(
    parameter int WIDTH = 16,
    parameter int RA    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_z,
    input  logic             in_v,
    input  logic             in_n,
    input  logic [RA-1:0]    in_rd,
    input  logic             in_wen,
    input  logic             in_setf,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [RA-1:0]    wb_rd,
    output logic             wb_wen,
    output logic [2:0]       flags,
    input  logic [2:0]       cond,
    output logic             cond_true,
    output logic [15:0]      wb_count
);

`ifdef ALU_WB_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             z;
        logic             v;
        logic             n;
        logic [RA-1:0]    rd;
        logic             wen;
        logic             setf;
    } entry_t;

    entry_t     in_entry;
    entry_t     head;
`ifdef ALU_WB_SKID_EN
    entry_t     tail;
`endif
    logic [1:0] count;
    logic       has_data;
    logic       full;
    logic       push;
    logic       pop;

    assign in_entry = '{result: in_result, z: in_z, v: in_v, n: in_n,
                        rd: in_rd, wen: in_wen, setf: in_setf};

    assign has_data = (count != 2'd0);
    assign full     = (count == 2'(DEPTH));

`ifdef ALU_WB_SKID_EN
    assign in_ready = !full && !flush;
`else
    assign in_ready = (!full || wb_ready) && !flush;
`endif

    assign wb_valid = has_data && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = wb_valid && wb_ready;

    assign wb_data  = head.result;
    assign wb_rd    = head.rd;
    assign wb_wen   = head.wen;

    // The head slot is always the oldest entry, so outputs come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
`ifdef ALU_WB_SKID_EN
            tail  <= '0;
`endif
        end else if (flush) begin
            count <= 2'd0;
        end else begin
`ifdef ALU_WB_SKID_EN
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_entry;
                    else               tail <= in_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= in_entry;
                    end else begin
                        head <= tail;
                        tail <= in_entry;
                    end
                end
                default: ;
            endcase
`else
            if (push) begin
                head  <= in_entry;
                count <= 2'd1;
            end else if (pop) begin
                count <= 2'd0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags    <= 3'b000;
            wb_count <= 16'd0;
        end else if (pop) begin
            wb_count <= wb_count + 16'd1;
            if (head.setf) flags <= {head.n, head.z, head.v};
        end
    end

    // flags is {n, z, v}
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = flags[1];
            3'b010: cond_true = !flags[1];
            3'b011: cond_true = flags[2] ^ flags[0];
            3'b100: cond_true = !(flags[2] ^ flags[0]);
            3'b101: cond_true = flags[2];
            3'b110: cond_true = flags[0];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage; builds with or without ALU_WB_SKID_EN.
module tb_alu_wb_stage;

`ifdef ALU_WB_SKID_EN
    localparam int EXP_DEPTH = 2;
`else
    localparam int EXP_DEPTH = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_z;
    logic        in_v;
    logic        in_n;
    logic [2:0]  in_rd;
    logic        in_wen;
    logic        in_setf;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        wb_wen;
    logic [2:0]  flags;
    logic [2:0]  cond;
    logic        cond_true;
    logic [15:0] wb_count;

    alu_wb_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_z      (in_z),
        .in_v      (in_v),
        .in_n      (in_n),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .in_setf   (in_setf),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .wb_wen    (wb_wen),
        .flags     (flags),
        .cond      (cond),
        .cond_true (cond_true),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] result;
        logic        z;
        logic        v;
        logic        n;
        logic [2:0]  rd;
        logic        wen;
        logic        setf;
        logic [2:0]  cond;
        logic [2:0]  exp_flags;
        logic        exp_cond;
    } vec_t;

    vec_t        vecs [9];
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  exp_flags;
    logic [15:0] exp_count;
    logic [15:0] bp_vals  [3];
    logic [15:0] got_vals [3];
    int          sent;
    int          got;
    int          retired;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid  = 1'b1;
        in_result = v.result;
        in_z      = v.z;
        in_v      = v.v;
        in_n      = v.n;
        in_rd     = v.rd;
        in_wen    = v.wen;
        in_setf   = v.setf;
        cond      = v.cond;
        #1;
    endtask

    initial begin
        //            result    z     v     n     rd    wen   setf  cond    flags   cond_true
        vecs[0] = '{16'h0002, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1};
        vecs[1] = '{16'h8000, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 3'b011, 3'b101, 1'b0};
        vecs[2] = '{16'h1234, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 3'b110, 3'b101, 1'b1};
        vecs[3] = '{16'h0000, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 3'b001, 3'b010, 1'b1};
        vecs[4] = '{16'hFFFE, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 3'b101, 3'b010, 1'b0};
        vecs[5] = '{16'h7FFF, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 3'b100, 3'b001, 1'b0};
        vecs[6] = '{16'h0001, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'b011, 3'b001, 1'b1};
        vecs[7] = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 3'b010, 3'b100, 1'b1};
        vecs[8] = '{16'h0005, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 3'b111, 3'b100, 1'b0};
        bp_vals[0] = 16'h0001;
        bp_vals[1] = 16'h0002;
        bp_vals[2] = 16'h0003;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0;
        in_z = 1'b0; in_v = 1'b0; in_n = 1'b0; in_rd = '0; in_wen = 1'b0; in_setf = 1'b0;
        wb_ready = 1'b1; cond = 3'b000;
        exp_flags = 3'b000; exp_count = 16'd0;

        #12 rst_n = 1'b1;
        @(negedge clk); #1;
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_wb_data",  wb_data, 0);
        checkOutput("rst_wb_rd",    wb_rd, 0);
        checkOutput("rst_wb_wen",   wb_wen, 0);
        checkOutput("rst_flags",    flags, 0);
        checkOutput("rst_wb_count", wb_count, 0);

        // One entry per vector: accept, present one cycle later, retire, then check flags.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wb_ready = 1'b1;
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_in_ready", i), in_ready, 1);
            checkOutput($sformatf("v%0d_no_comb_path", i), wb_valid, 0);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checkOutput($sformatf("v%0d_wb_valid", i), wb_valid, 1);
            checkOutput($sformatf("v%0d_wb_data", i), wb_data, vecs[i].result);
            checkOutput($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].rd);
            checkOutput($sformatf("v%0d_wb_wen", i), wb_wen, vecs[i].wen);
            exp_count = exp_count + 16'd1;
            @(negedge clk); #1;
            exp_flags = vecs[i].exp_flags;
            checkOutput($sformatf("v%0d_flags", i), flags, exp_flags);
            checkOutput($sformatf("v%0d_cond_true", i), cond_true, vecs[i].exp_cond);
            checkOutput($sformatf("v%0d_wb_count", i), wb_count, exp_count);
            checkOutput($sformatf("v%0d_empty", i), wb_valid, 0);
        end

        // Backpressure: stall the register file while three results are offered.
        sent = 0; got = 0;
        in_setf = 1'b0; in_wen = 1'b1; in_rd = 3'd2; in_z = 1'b0; in_v = 1'b0; in_n = 1'b0;
        @(negedge clk);
        wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid  = (sent < 3);
            in_result = bp_vals[(sent < 3) ? sent : 2];
            #1;
            if (c > 0) checkOutput("bp_head_stable", wb_data, 16'h0001);
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        #1;
        checkOutput("bp_accepted", sent, EXP_DEPTH);
        checkOutput("bp_in_ready_low", in_ready, 0);
        checkOutput("bp_wb_valid", wb_valid, 1);
        wb_ready = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            in_valid  = (sent < 3);
            in_result = bp_vals[(sent < 3) ? sent : 2];
            #1;
            if (wb_valid && wb_ready) begin
                got_vals[got] = wb_data;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("bp_retired", got, 3);
        for (int k = 0; k < 3; k++)
            if (k < got) checkOutput($sformatf("bp_order%0d", k), got_vals[k], bp_vals[k]);
        exp_count = exp_count + 16'd3;
        #1;
        checkOutput("bp_wb_count", wb_count, exp_count);
        checkOutput("bp_flags", flags, exp_flags);

        // Flush with the buffer full; the beat presented alongside flush is dropped.
        wb_ready = 1'b0;
        for (int k = 0; k < EXP_DEPTH; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_result = 16'h0010 + 16'(k); in_setf = 1'b1; in_z = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("fl_buffered", wb_valid, 1);
        flush = 1'b1; in_valid = 1'b1; in_result = 16'h0099;
        #1;
        checkOutput("fl_in_ready", in_ready, 0);
        checkOutput("fl_wb_valid_comb", wb_valid, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checkOutput("fl_wb_valid", wb_valid, 0);
        checkOutput("fl_flags", flags, exp_flags);
        checkOutput("fl_wb_count", wb_count, exp_count);
        wb_ready = 1'b1;
        @(negedge clk); #1;
        checkOutput("fl_no_retire", wb_count, exp_count);
        checkOutput("fl_still_empty", wb_valid, 0);

        // Asynchronous reset while an entry is buffered and flags are non-zero.
        applyStimulus('{16'h00AA, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 3'b000, 3'b101, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); #1;
        checkOutput("rs_flags_set", flags, 3'b101);
        wb_ready = 1'b0;
        applyStimulus('{16'h0033, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 3'b000, 3'b101, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("rs_buffered", wb_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rs_wb_valid", wb_valid, 0);
        checkOutput("rs_wb_data", wb_data, 0);
        checkOutput("rs_wb_rd", wb_rd, 0);
        checkOutput("rs_wb_wen", wb_wen, 0);
        checkOutput("rs_flags", flags, 0);
        checkOutput("rs_wb_count", wb_count, 0);
        checkOutput("rs_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 16'd0;

        // Counter wrap: stream 65535 retirements, then one more.
        sent = 0; retired = 0; wb_ready = 1'b1; in_setf = 1'b0;
        for (int c = 0; c < 70000 && retired < 65535; c++) begin
            @(negedge clk);
            in_valid  = (sent < 65535);
            in_result = 16'(sent);
            #1;
            if (in_valid && in_ready) sent++;
            if (wb_valid && wb_ready) retired++;
        end
        in_valid = 1'b0;
        checkOutput("wrap_retired", retired, 65535);
        @(negedge clk); #1;
        checkOutput("wrap_ffff", wb_count, 16'hFFFF);
        applyStimulus('{16'h4242, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); #1;
        checkOutput("wrap_zero", wb_count, 16'h0000);
        checkOutput("wrap_flags", flags, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
